// File: rtl/regs_pkg.sv
// Shared register-file constants and address type for the writeback path.
package regs_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Request vector to one-hot grant. Round-robin when REGS_WB_ARB_RR_EN is defined,
// otherwise a lowest-index-wins priority encoder with no state.
module rr_arbiter
  import regs_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

`ifdef REGS_WB_ARB_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;
  logic          found;

  // Two passes: indices at/above the pointer first, then wrap to the low ones.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_ptr;
    end
  end
`else
  logic found;
  logic unused_ok;

  assign unused_ok = ^{clk, rst, advance};

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter for the register-file write port plus pending-write scoreboard.
// Arbitration is round-robin when REGS_WB_ARB_RR_EN is defined, fixed priority otherwise.
module regs_wb_arbiter
  import regs_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_in,
  input  logic [NREQ*AW-1:0]   req_addr_in,
  input  logic [NREQ*XLEN-1:0] req_data_in,
  output logic [NREQ-1:0]      req_ready_out,
  output logic                 regs_wen_out,
  output logic [AW-1:0]        regs_write_addr_out,
  output logic [XLEN-1:0]      regs_write_data_out,
  input  logic                 issue_valid_in,
  input  logic [AW-1:0]        issue_addr_in,
  output logic [NUM_REGS-1:0]  pending_out
);

  logic [NREQ-1:0]     arb_grant;
  logic                accept;
  logic [AW-1:0]       sel_addr;
  logic [XLEN-1:0]     sel_data;
  logic                wen_q;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid_in),
    .advance (accept),
    .grant   (arb_grant)
  );

  assign req_ready_out = rst ? '0 : arb_grant;
  assign accept        = |req_ready_out;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready_out[i]) begin
        sel_addr = sel_addr | req_addr_in[i*AW +: AW];
        sel_data = sel_data | req_data_in[i*XLEN +: XLEN];
      end
    end
  end

  // Address 0 is consumed like any other request but never reaches the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q               <= 1'b0;
      regs_write_addr_out <= '0;
      regs_write_data_out <= '0;
    end else begin
      wen_q <= accept && (sel_addr != '0);
      if (accept) begin
        regs_write_addr_out <= sel_addr;
        regs_write_data_out <= sel_data;
      end
    end
  end

  // A write registered just before reset must not land while reset is held.
  assign regs_wen_out = wen_q & ~rst;

  always_comb begin
    pending_next = pending_q;
    if (regs_wen_out) begin
      pending_next[regs_write_addr_out] = 1'b0;
    end
    if (issue_valid_in && (issue_addr_in != '0)) begin
      pending_next[issue_addr_in] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

  assign pending_out = pending_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter; expectations follow REGS_WB_ARB_RR_EN when defined.
module tb_regs_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            wen;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*XLEN-1:0] req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 regs_wen;
  logic [AW-1:0]        regs_addr;
  logic [XLEN-1:0]      regs_data;
  logic                 issue_valid = 1'b0;
  logic [AW-1:0]        issue_addr = '0;
  logic [31:0]          pending;

  int          errors = 0;
  int          checks = 0;
  int          rr_ptr = 0;
  logic [31:0] exp_pending = '0;
  wr_t         exp_q[$];

  logic [NREQ-1:0] obs_ready;
  logic            obs_wen;
  logic [AW-1:0]   obs_addr;
  logic [XLEN-1:0] obs_data;
  logic [31:0]     obs_pending;

  regs_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_in        (req_valid),
    .req_addr_in         (req_addr),
    .req_data_in         (req_data),
    .req_ready_out       (req_ready),
    .regs_wen_out        (regs_wen),
    .regs_write_addr_out (regs_addr),
    .regs_write_data_out (regs_data),
    .issue_valid_in      (issue_valid),
    .issue_addr_in       (issue_addr),
    .pending_out         (pending)
  );

  always #5 clk = ~clk;

  // A requester that was not granted must keep its request up.
  for (genvar g = 0; g < NREQ; g++) begin : g_hs
    assert property (@(posedge clk) disable iff (rst)
                     (req_valid[g] && !req_ready[g]) |=> req_valid[g])
      else $error("[TB] handshake violation on requester %0d", g);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    req_valid[idx]            = v;
    req_addr[idx*AW +: AW]    = a;
    req_data[idx*XLEN +: XLEN] = d;
  endtask

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] g;
    g = '0;
`ifdef REGS_WB_ARB_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (g == '0 && v[idx]) g[idx] = 1'b1;
    end
`else
    if (ptr < 0) g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (g == '0 && v[k]) g[k] = 1'b1;
    end
`endif
    return g;
  endfunction

  task automatic modelReset();
    exp_q.delete();
    exp_q.push_back('0);
    rr_ptr      = 0;
    exp_pending = '0;
  endtask

  // One clock: sample at negedge, check against the model, schedule next-cycle expectations.
  task automatic cycle();
    wr_t             e;
    wr_t             n;
    logic [NREQ-1:0] g;
    @(negedge clk);
    obs_ready   = req_ready;
    obs_wen     = regs_wen;
    obs_addr    = regs_addr;
    obs_data    = regs_data;
    obs_pending = pending;
    g = model_grant(req_valid, rr_ptr);
    checkOutput("ready", obs_ready, g);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checkOutput("wen", obs_wen, e.wen);
    if (e.wen) begin
      checkOutput("waddr", obs_addr, e.addr);
      checkOutput("wdata", obs_data, e.data);
    end
    checkOutput("pending", obs_pending, exp_pending);
    n = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        n.addr = req_addr[i*AW +: AW];
        n.data = req_data[i*XLEN +: XLEN];
        n.wen  = (n.addr != '0);
`ifdef REGS_WB_ARB_RR_EN
        rr_ptr = (i + 1) % NREQ;
`endif
      end
    end
    exp_q.push_back(n);
    if (e.wen) exp_pending[e.addr] = 1'b0;
    if (issue_valid && issue_addr != '0) exp_pending[issue_addr] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst         = 1'b1;
    req_valid   = '0;
    issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_wen", regs_wen, 0);
    checkOutput("rst_addr", regs_addr, 0);
    checkOutput("rst_data", regs_data, 0);
    checkOutput("rst_pending", pending, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && req_valid != '0; k++) begin
      cycle();
      req_valid = req_valid & ~obs_ready;
    end
    checkOutput("drain_done", req_valid, 0);
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;

    applyReset();

    // Single request and one-cycle write latency.
    applyStimulus(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    checkOutput("single_ready", obs_ready, 3'b001);
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    cycle();
    checkOutput("single_wen", obs_wen, 1);
    checkOutput("single_addr", obs_addr, 5);
    checkOutput("single_data", obs_data, 32'hDEADBEEF);
    cycle();
    checkOutput("single_idle", obs_wen, 0);

    // Address 0 is accepted but never written.
    applyStimulus(1, 1'b1, 5'd0, 32'h1234);
    cycle();
    checkOutput("zero_ready", obs_ready, 3'b010);
    applyStimulus(1, 1'b0, 5'd0, 32'h0);
    cycle();
    checkOutput("zero_wen", obs_wen, 0);

    // All three continuously valid for six cycles.
    applyReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, AW'(i + 1), 32'h100 + i);
    for (int c = 0; c < 6; c++) begin
      cycle();
`ifdef REGS_WB_ARB_RR_EN
      exp_g = NREQ'(1 << (c % NREQ));
`else
      exp_g = 3'b001;
`endif
      checkOutput($sformatf("grant%0d", c), obs_ready, exp_g);
      for (int i = 0; i < NREQ; i++)
        if (obs_ready[i]) req_data[i*XLEN +: XLEN] = req_data[i*XLEN +: XLEN] + 32'h10;
    end
    drain();
    cycle();

    // Scoreboard set on issue, clear two cycles after accept.
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    cycle();
    issue_valid = 1'b0;
    cycle();
    checkOutput("pend7_set", obs_pending[7], 1);
    cycle();
    applyStimulus(2, 1'b1, 5'd7, 32'hCAFE0007);
    cycle();
    checkOutput("pend7_ready", obs_ready, 3'b100);
    applyStimulus(2, 1'b0, 5'd0, 32'h0);
    cycle();
    checkOutput("pend7_wen", obs_wen, 1);
    checkOutput("pend7_still", obs_pending[7], 1);
    cycle();
    checkOutput("pend7_clear", obs_pending[7], 0);

    // Same-cycle set and clear of one address keeps it pending.
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    cycle();
    issue_valid = 1'b0;
    applyStimulus(0, 1'b1, 5'd9, 32'h99);
    cycle();
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    cycle();
    checkOutput("coll_wen", obs_wen, 1);
    checkOutput("coll_addr", obs_addr, 9);
    issue_valid = 1'b0;
    cycle();
    checkOutput("coll_pend9", obs_pending[9], 1);

    // Reset right after an accept drops the write and restarts arbitration at 0.
    issue_valid = 1'b1;
    issue_addr  = 5'd12;
    cycle();
    issue_valid = 1'b0;
    applyStimulus(0, 1'b1, 5'd3, 32'h3333);
    cycle();
    checkOutput("mid_ready", obs_ready, 3'b001);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, AW'(i + 4), 32'h400 + i);
    @(negedge clk);
    checkOutput("mid_rst_wen", regs_wen, 0);
    checkOutput("mid_rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    cycle();
    checkOutput("post_rst_grant", obs_ready, 3'b001);
    checkOutput("post_rst_pending", obs_pending, 0);
    req_valid = req_valid & ~obs_ready;
    drain();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
